adder_tree_arbiter: RTL and testbench
=====================================

ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 28, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one 8-leaf adder tree.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port req_valid  in  NUM_REQ  per-requester operand-set valid.
REQ-005 SHALL have port req_ready  out  NUM_REQ  per-requester accept; transfer on valid&ready at clk edge.
REQ-006 SHALL have port req_data  in  NUM_REQ*8*ADDER_WIDTH  packed operands; requester i at slice i, leaf j at sub-slice j.
REQ-007 SHALL have port res_valid  out  1  result valid.
REQ-008 SHALL have port res_ready  in  1  downstream accept.
REQ-009 SHALL have port res_sum  out  ADDER_WIDTH+3  full-precision sum of the 8 operands.
REQ-010 SHALL have port res_id  out  clog2(NUM_REQ)  index of the requester that owns res_sum.
REQ-011 SHALL have port busy  out  1  high while any pipeline stage holds a valid entry.

Function
REQ-012 Arbitration SHALL be round-robin: priority pointer ptr; grant = first i with req_valid[i] searching ptr, ptr+1, ... mod NUM_REQ.
REQ-013 At most one req_ready bit SHALL be high per cycle; req_ready[i] = grant[i] & ~stall; req_ready may depend on req_valid, req_valid must not depend on req_ready.
REQ-014 On a transfer from requester g, ptr SHALL become (g+1) mod NUM_REQ next cycle; with no transfer ptr SHALL hold.
REQ-015 Pipeline SHALL have 2 stages: S1 registers 8 operands + id + valid; S2 registers tree sum + id + valid, driving res_*.
REQ-016 Latency: transfer in cycle C SHALL give res_valid=1 with that result in cycle C+2 absent stall; throughput one set per cycle.
REQ-017 stall = res_valid & ~res_ready; while stall, S1 and S2 SHALL hold, all req_ready SHALL be 0, res_sum/res_id SHALL remain stable.
REQ-018 Result SHALL leave on res_valid&res_ready; S2 empty and S1 empty SHALL never stall.
REQ-019 Arithmetic SHALL be unsigned, zero-extended per level (+1 bit per level), no truncation; max result 8*(2^ADDER_WIDTH-1).
REQ-020 Results SHALL emerge in grant order; no set lost or duplicated.
REQ-021 busy = S1.valid | S2.valid.

Reset
REQ-022 On rst: ptr=0, S1/S2 valid=0, res_valid=0, res_sum=0, res_id=0, busy=0, req_ready=0 in reset cycles.
REQ-023 rst mid-operation SHALL discard in-flight entries; no stale result SHALL appear after rst deasserts.
REQ-024 First grant after rst deassertion SHALL follow REQ-012 with ptr=0.

Structure
REQ-025 Package adder_tree_pkg SHALL hold NUM_LEAVES=8, TREE_LEVELS=3, default ADDER_WIDTH, and id-width constant/function.
REQ-026 Sub-module adder_tree_pipe SHALL implement the 3-level tree S1->S2 with stall-enable; arbiter, ptr and handshake stay in adder_tree_arbiter.

Verification
REQ-027 Req 0 only, operands 1..8, res_ready=1 -> cycle C+2 res_valid=1, res_sum=36, res_id=0, then res_valid=0.
REQ-028 All 8 operands 0xFFFFFFF (ADDER_WIDTH=28) -> res_sum=0x7FFFFFF8, no overflow.
REQ-029 All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; res_id same sequence from C+2.
REQ-030 Pipeline full, res_ready=0 for 3 cycles -> req_ready=0, res_sum/res_id constant, busy=1; on res_ready=1 results resume in order, none lost.
REQ-031 Requesters 1,3 valid, ptr=2 -> grant 3, then ptr=0 -> grant 1.
REQ-032 rst asserted with 2 entries in flight -> next cycle res_valid=0, busy=0; after deassert no stale result, first grant to lowest valid index.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared constants for the arbitrated 8-leaf adder tree
// Purpose: tree geometry, default operand width and requester-id width helper.
package adder_tree_pkg;

    localparam int NUM_LEAVES          = 8;
    localparam int TREE_LEVELS         = 3;
    localparam int DEFAULT_ADDER_WIDTH = 28;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - two-stage 8-leaf unsigned adder tree with hold enable
// Purpose: S1 captures operands/id/valid, S2 captures the full-precision tree sum.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  advance both stages (low = hold everything)
//   in_valid/in_data/in_id   operand set entering S1
//   s1_valid            S1 occupancy (for busy)
//   out_valid/out_sum/out_id S2 contents, driven straight to the result port
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter int ID_W        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic [NUM_LEAVES*ADDER_WIDTH-1:0] in_data,
    input  logic [ID_W-1:0]                   in_id,
    output logic                              s1_valid,
    output logic                              out_valid,
    output logic [ADDER_WIDTH+TREE_LEVELS-1:0] out_sum,
    output logic [ID_W-1:0]                   out_id
);

    logic [NUM_LEAVES*ADDER_WIDTH-1:0] s1_data;
    logic [ID_W-1:0]                   s1_id;

    // Each level widens by one bit so no carry is ever dropped.
    logic [ADDER_WIDTH:0]   lvl1 [4];
    logic [ADDER_WIDTH+1:0] lvl2 [2];
    logic [ADDER_WIDTH+2:0] lvl3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = {1'b0, s1_data[(2*i)*ADDER_WIDTH +: ADDER_WIDTH]}
                    + {1'b0, s1_data[(2*i+1)*ADDER_WIDTH +: ADDER_WIDTH]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        lvl3 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_data   <= in_data;
            s1_id     <= in_id;
            out_valid <= s1_valid;
            out_sum   <= lvl3;
            out_id    <= s1_id;
        end
    end

endmodule

// File: rtl/adder_tree_arbiter.sv
// rtl/adder_tree_arbiter.sv - round-robin arbiter feeding a shared pipelined adder tree
// Purpose: picks one requester per cycle, hands its 8 operands to the tree pipe,
//          and returns the sum tagged with the requester index.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready/req_data  per-requester operand sets (NUM_REQ x 8 x ADDER_WIDTH)
//   res_valid/res_ready           result handshake
//   res_sum/res_id                full-precision sum and owning requester
//   busy                          any pipeline stage occupied
module adder_tree_arbiter
    import adder_tree_pkg::*;
#(
    parameter  int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter  int NUM_REQ     = 4,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*NUM_LEAVES*ADDER_WIDTH-1:0] req_data,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [ADDER_WIDTH+TREE_LEVELS-1:0]        res_sum,
    output logic [ID_W-1:0]                           res_id,
    output logic                                      busy
);

    localparam int SET_W = NUM_LEAVES * ADDER_WIDTH;

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;
    int                   grant_off;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 stall;
    logic                 take;
    logic                 s1_valid;

    assign stall = res_valid & ~res_ready;

    // Rotate the request vector so bit 0 is the requester at ptr; the first
    // set bit is then the distance from ptr to the winner.
    assign dbl = {req_valid, req_valid} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        grant_any = 1'b0;
        grant_off = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && rot[k]) begin
                grant_any = 1'b1;
                grant_off = k;
            end
        end
        grant_id = ID_W'((int'(ptr) + grant_off) % NUM_REQ);
    end

    // A grant only becomes a transfer when the pipe can move and we are not in reset.
    assign take      = grant_any & ~stall & ~rst;
    assign req_ready = take ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
        end
    end

    adder_tree_pipe #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .ID_W        (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (~stall),
        .in_valid  (take),
        .in_data   (req_data[int'(grant_id)*SET_W +: SET_W]),
        .in_id     (grant_id),
        .s1_valid  (s1_valid),
        .out_valid (res_valid),
        .out_sum   (res_sum),
        .out_id    (res_id)
    );

    assign busy = s1_valid | res_valid;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// tb/tb_adder_tree_arbiter.sv - randomized self-checking bench for adder_tree_arbiter
module tb_adder_tree_arbiter;

    localparam int W   = 28;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int DW  = N * 8 * W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [DW-1:0]  req_data;
    logic           res_valid;
    logic           res_ready;
    logic [W+2:0]   res_sum;
    logic [IDW-1:0] res_id;
    logic           busy;

    always #5 clk = ~clk;

    adder_tree_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    typedef struct {
        longint unsigned sum;
        int              id;
        int              age;
    } ent_t;

    ent_t mq[$];
    int   m_ptr;
    int   n_cmp;
    int   n_err;

    function automatic longint unsigned set_sum(input int g);
        longint unsigned s = 0;
        for (int j = 0; j < 8; j++) s += req_data[(g*8+j)*W +: W];
        return s;
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].age >= 2);
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g = m_grant();
        if (rst || g < 0 || (m_valid() && !res_ready)) return '0;
        return N'(1) << g;
    endfunction

    task automatic rand_data();
        for (int w = 0; w < DW/32; w++) req_data[w*32 +: 32] = $urandom;
    endtask

    // Advance the reference model by the edge about to happen, then step past it.
    task automatic tick();
        int g;
        bit st;
        if (rst) begin
            mq.delete();
            m_ptr = 0;
        end else begin
            st = m_valid() && !res_ready;
            if (!st) begin
                if (m_valid()) void'(mq.pop_front());
                foreach (mq[i]) mq[i].age++;
                g = m_grant();
                if (g >= 0) begin
                    mq.push_back('{set_sum(g), g, 1});
                    m_ptr = (g + 1) % N;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; res_ready = 1'b1; rand_data();
        tick(); tick();
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (res_sum !== '0 || res_id !== '0) begin n_err++; $display("FAIL reset_res got sum %h id %0d want 0/0", res_sum, res_id); end
        rst = 1'b0; req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0001; res_ready = 1'b1; rand_data();
        for (int j = 0; j < 8; j++) req_data[j*W +: W] = W'(j + 1);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick(); req_valid = '0; #1;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_c1_valid got %b want 0", res_valid); end
        tick(); #1;
        n_cmp++; if (res_valid !== 1'b1 || res_sum !== 31'd36 || res_id !== 2'd0) begin
            n_err++; $display("FAIL single_c2 got v%b sum %0d id %0d want v1 sum 36 id 0", res_valid, res_sum, res_id);
        end
        tick(); #1;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_c3_valid got %b want 0", res_valid); end
    endtask

    task automatic test_max();
        req_valid = 4'b0001; res_ready = 1'b1; rand_data();
        for (int j = 0; j < 8; j++) req_data[j*W +: W] = 28'hFFFFFFF;
        #1; tick(); req_valid = '0; #1; tick(); #1;
        n_cmp++; if (res_valid !== 1'b1 || res_sum !== 31'h7FFFFFF8) begin
            n_err++; $display("FAIL max_sum got v%b sum %h want v1 sum 7ffffff8", res_valid, res_sum);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = '1; res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rand_data(); #1;
            n_cmp++; if (req_ready !== (4'b0001 << (c % 4))) begin
                n_err++; $display("FAIL rr_grant c%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4));
            end
            if (c >= 2) begin
                n_cmp++; if (res_valid !== 1'b1 || int'(res_id) !== (c - 2) % 4 || {33'b0, res_sum} !== mq[0].sum) begin
                    n_err++; $display("FAIL rr_result c%0d got v%b id %0d sum %h want v1 id %0d sum %h",
                                      c, res_valid, res_id, res_sum, (c - 2) % 4, mq[0].sum);
                end
            end
            tick();
        end
        req_valid = '0;
        tick(); tick();
    endtask

    task automatic test_stall();
        logic [W+2:0]   hold_sum;
        logic [IDW-1:0] hold_id;
        req_valid = '1; res_ready = 1'b1;
        rand_data(); tick(); rand_data(); tick(); rand_data();
        res_ready = 1'b0; #1;
        hold_sum = res_sum; hold_id = res_id;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1 || res_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_ctrl c%0d got ready %b busy %b valid %b want 0000/1/1", c, req_ready, busy, res_valid);
            end
            n_cmp++; if (res_sum !== hold_sum || res_id !== hold_id) begin
                n_err++; $display("FAIL stall_hold c%0d got %h/%0d want %h/%0d", c, res_sum, res_id, hold_sum, hold_id);
            end
            tick(); rand_data(); #1;
        end
        res_ready = 1'b1; req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (res_valid !== m_valid()) begin n_err++; $display("FAIL stall_drain_valid c%0d got %b want %b", c, res_valid, m_valid()); end
            if (m_valid()) begin
                n_cmp++; if ({33'b0, res_sum} !== mq[0].sum || int'(res_id) !== mq[0].id) begin
                    n_err++; $display("FAIL stall_drain_data c%0d got %h/%0d want %h/%0d", c, res_sum, res_id, mq[0].sum, mq[0].id);
                end
            end
            tick();
        end
        #1;
        n_cmp++; if (busy !== 1'b0 || mq.size() != 0) begin n_err++; $display("FAIL stall_empty got busy %b left %0d want 0/0", busy, mq.size()); end
    endtask

    task automatic test_skip();
        rst = 1'b1; tick(); rst = 1'b0;
        res_ready = 1'b1; req_valid = 4'b0010; rand_data();
        tick();
        req_valid = 4'b1010; #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL skip_first got %b want 1000", req_ready); end
        tick(); #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL skip_second got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midflight();
        int seen;
        res_ready = 1'b1; req_valid = '1;
        rand_data(); tick(); rand_data(); tick();
        rst = 1'b1; req_valid = '0; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
        tick(); rst = 1'b0; #1;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_flush got v%b busy %b want 0/0", res_valid, busy); end
        req_valid = 4'b0110; rand_data(); #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_first_grant got %b want 0010", req_ready); end
        tick(); req_valid = '0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (res_valid === 1'b1) begin
                seen++;
                n_cmp++; if (res_id !== 2'd1 || {33'b0, res_sum} !== mq[0].sum) begin
                    n_err++; $display("FAIL mid_result got id %0d sum %h want id 1 sum %h", res_id, res_sum, mq[0].sum);
                end
            end
            tick();
        end
        n_cmp++; if (seen != 1) begin n_err++; $display("FAIL mid_count got %0d want 1", seen); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom % 80) == 0;
            req_valid = N'($urandom);
            res_ready = ($urandom % 4) != 0;
            rand_data();
            #1;
            n_cmp++; if (req_ready !== m_ready()) begin n_err++; $display("FAIL rand_ready c%0d got %b want %b", c, req_ready, m_ready()); end
            n_cmp++; if (res_valid !== m_valid() || busy !== (mq.size() > 0)) begin
                n_err++; $display("FAIL rand_state c%0d got v%b busy %b want v%b busy %b", c, res_valid, busy, m_valid(), mq.size() > 0);
            end
            if (m_valid()) begin
                n_cmp++; if ({33'b0, res_sum} !== mq[0].sum || int'(res_id) !== mq[0].id) begin
                    n_err++; $display("FAIL rand_data c%0d got %h/%0d want %h/%0d", c, res_sum, res_id, mq[0].sum, mq[0].id);
                end
            end
            tick();
        end
        rst = 1'b0; req_valid = '0; res_ready = 1'b1;
        tick(); tick(); tick(); #1;
        n_cmp++; if (busy !== 1'b0 || mq.size() != 0) begin n_err++; $display("FAIL rand_drain got busy %b left %0d want 0/0", busy, mq.size()); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_ptr = 0;
        rst = 1'b1; req_valid = '0; res_ready = 1'b1; req_data = '0;
        test_reset();
        test_single();
        test_max();
        test_round_robin();
        test_stall();
        test_skip();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
